controlador_display_mux: RTL and testbench
==========================================

# controlador_display_mux

Time-multiplexed scan controller for a common-anode, multi-digit 7-segment display. It holds a NUM_DIGITS-nibble value, rotates an active-low anode strobe across the digits at a programmable rate, and drives the shared active-low segment bus through a hex-to-7-segment decoder. It sits between the system datapath (the producer of the value) and the board's display pins. Updates use a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4, number of scanned digits; legal range 2..8.
- PRESCALE, 50000, clock cycles each digit stays lit; minimum 2.
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_Dato  input  4*NUM_DIGITS  value to display; nibble k (bits 4k+3:4k) goes to digit k, and digit 0 is the least significant (rightmost).
- i_Valido  input  1  producer asserts while i_Dato is valid.
- o_Listo  output  1  block can accept an update; the transfer occurs on a cycle where i_Valido and o_Listo are both high.
- o_Anodos  output  NUM_DIGITS  active-low digit enables; at most one bit is low.
- o_Segmentos  output  7  active-low segments, {a,b,c,d,e,f,g} = bits 6..0.
- o_Frame  output  1  one-cycle pulse on the last cycle of each full scan.

## Operation
- Registers: prescaler cnt (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), pending buffer plus flag pend, display register disp.
- Reset values:
  - cnt=0, idx=0, pend=0, disp=0.
  - o_Anodos all 1, o_Segmentos=7'b1111111, o_Frame=0.
  - o_Listo=1.
- Prescaler: cnt increments every cycle and wraps at PRESCALE-1. Define tick = (cnt==PRESCALE-1).
- Digit advance: on tick, idx increments and wraps from NUM_DIGITS-1 to 0.
- Frame boundary (fb) = tick and idx==NUM_DIGITS-1.
- Handshake:
  - o_Listo = !pend, driven combinationally.
  - On accept, the pending buffer captures i_Dato and pend is set.
  - While o_Listo=0, i_Valido is ignored. The producer must hold i_Dato/i_Valido until accepted.
- Commit: on fb with pend=1, disp is loaded from the pending buffer and pend clears.
- Simultaneous accept and fb (pend=0): the data goes to the pending buffer and is committed at the next fb, not the current one.
- Decode uses standard hex glyphs, 0 = lit. Examples:
  - 0 → 0000001, 1 → 1001111, 8 → 0000000.
  - A → 0001000, b → 1100000, F → 0111000.
- Outputs are registered: o_Anodos and o_Segmentos update on the same edge, so the segment bus never carries a glitch between digits.
- Reset mid-frame blanks all digits immediately (asynchronously) and discards any pending data.

## Timing
- Outputs are a one-register stage behind idx. Digit k is lit for exactly PRESCALE cycles per frame.
- Frame period is NUM_DIGITS*PRESCALE cycles.
- First edge after reset release: o_Anodos bit 0 low, showing disp nibble 0 (0 after reset).
- Accept-to-visible latency:
  - Minimum: one cycle before fb (the data appears on digit 0 of the next frame).
  - Maximum: one frame plus one cycle.
- o_Frame is high in the cycle where fb is true, aligned with the commit.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Zero nibbles above the most significant nonzero nibble of disp output 7'b1111111.
  - Their anodes still scan, so brightness and timing are unchanged.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Not defined: every digit shows its glyph, including leading zeros.

## Structure
- Package display_pkg holds:
  - SEG_OFF = 7'b1111111.
  - The 16-entry hex glyph constant table.
  - The anode-off pattern.
- Sub-module deco_hex_7seg: purely combinational, 4-bit in and 7-bit out. The top-level output register follows it.
- Counter widths are $clog2(PRESCALE) and $clog2(NUM_DIGITS).

## Test plan
Each scenario uses PRESCALE=4 and NUM_DIGITS=4.
- Reset release with no update: anodes cycle 1110 → 1101 → 1011 → 0111, each for 4 cycles, with segments 0000001 on every digit. o_Frame pulses every 16 cycles.
- Accept i_Dato=16'h1A8F mid-frame: o_Listo drops the next cycle. After fb, the segments show F, 8, A, 1 on digits 0..3 and o_Listo returns high.
- Second i_Valido while pend=1: it is not accepted. The displayed value stays the first update until the producer retries after o_Listo=1.
- Accept coincident with fb: the old value is shown for one more full frame, then the new one.
- Assert i_Rst mid-scan: within the same cycle the anodes are 1111 and segments 1111111, and pend is cleared.
- With LEADING_ZERO_BLANK_EN, i_Dato=16'h0050: digits 3 and 2 show 1111111, digit 1 shows 0100100, digit 0 shows 0000001. With 16'h0000, only digit 0 is lit.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// blank segment pattern, anode-off pattern and the hex glyph table.
// Segment order is {a,b,c,d,e,f,g} = bits 6..0, active-low (0 = lit).
package display_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Wide enough for the largest legal digit count; slice to NUM_DIGITS.
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return HEX_GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/deco_hex_7seg.sv
// Combinational hex-to-7-segment decoder (active-low, {a..g} = bits 6..0).
module deco_hex_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Segmentos
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    o_Segmentos = hex_glyph(i_Nibble);
  end

endmodule

// File: rtl/controlador_display_mux.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display. Accepts a new value through a valid/ready handshake
// and commits it only at frame boundaries so a frame never mixes digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero nibble (digit 0 is never blanked).
module controlador_display_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
)
(
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [4*NUM_DIGITS-1:0] i_Dato,
  input  logic                    i_Valido,
  output logic                    o_Listo,
  output logic [NUM_DIGITS-1:0]   o_Anodos,
  output logic [6:0]              o_Segmentos,
  output logic                    o_Frame
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    pend;
  logic [4*NUM_DIGITS-1:0] pend_buf;
  logic [4*NUM_DIGITS-1:0] disp;

  logic                    tick;
  logic                    fb;
  logic                    accept;
  logic [3:0]              nibble;
  logic [6:0]              glyph;
  logic                    blank_cur;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   anode_next;

  // Scan timing strobes and handshake qualifiers.
  always_comb begin
    tick    = (cnt == CNT_LAST);
    fb      = tick && (idx == IDX_LAST);
    accept  = i_Valido && !pend;
    o_Listo = !pend;
    o_Frame = fb;
  end

  // Prescaler: one tick every PRESCALE cycles.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advances on each tick and wraps after the last digit.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Pending buffer and display register. A commit only happens with
  // pend=1, and accept only with pend=0, so an accept coinciding with a
  // frame boundary waits for the following boundary.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pend     <= 1'b0;
      pend_buf <= '0;
      disp     <= '0;
    end else begin
      if (fb && pend) begin
        disp <= pend_buf;
        pend <= 1'b0;
      end
      if (accept) begin
        pend_buf <= i_Dato;
        pend     <= 1'b1;
      end
    end
  end

  // Select the nibble and anode pattern for the current digit.
  always_comb begin
    nibble     = '0;
    anode_next = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble        = disp[4*k +: 4];
        anode_next[k] = 1'b0;
      end
    end
  end

  deco_hex_7seg u_deco (
    .i_Nibble    (nibble),
    .o_Segmentos (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;

  // A digit above 0 is blank when it and every digit above it are zero.
  always_comb begin
    blank_mask = '0;
    blank_cur  = 1'b0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      blank_mask[k] = ((disp >> (4*k)) == '0);
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        blank_cur = blank_mask[k];
      end
    end
  end
`else
  // Every digit shows its glyph, leading zeros included.
  always_comb begin
    blank_cur = 1'b0;
  end
`endif

  // Blanked digits keep scanning their anode; only segments go dark.
  always_comb begin
    seg_next = blank_cur ? SEG_OFF : glyph;
  end

  // Registered anode/segment outputs change together on one edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Anodos    <= ANODES_OFF[NUM_DIGITS-1:0];
      o_Segmentos <= SEG_OFF;
    end else begin
      o_Anodos    <= anode_next;
      o_Segmentos <= seg_next;
    end
  end

endmodule

// File: tb/tb_controlador_display_mux.sv
// Self-checking bench for controlador_display_mux (NUM_DIGITS=4, PRESCALE=4).
// The reference model tracks cycles since reset and derives the shown digit,
// frame boundaries and commit points arithmetically from the cycle count.
module tb_controlador_display_mux;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   dato;
  logic          valido;
  logic          listo;
  logic [3:0]    anodos;
  logic [6:0]    segs;
  logic          frame;

  always #5 clk = ~clk;

  controlador_display_mux #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Dato      (dato),
    .i_Valido    (valido),
    .o_Listo     (listo),
    .o_Anodos    (anodos),
    .o_Segmentos (segs),
    .o_Frame     (frame)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int unsigned ncyc;     // active edges since reset release
  logic        m_pend;
  logic [15:0] m_buf;
  logic [15:0] m_disp;

  typedef struct packed {
    logic [15:0]     dato;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int k);
    logic [15:0] sh;
    sh = val >> (4*k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && sh == 16'h0) return 7'b1111111;
`endif
    return glyph(sh[3:0]);
  endfunction

  function automatic vec_t mk(input logic [15:0] d, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3);
    vec_t v;
    v.dato   = d;
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = e3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model across the edge and compare all outputs.
  task automatic step(output logic acc);
    int unsigned d;
    logic        fb;
    logic [15:0] disp_before;
    logic [3:0]  an_exp;
    d           = (ncyc / PS) % ND;
    fb          = (ncyc % FRAME) == FRAME - 1;
    acc         = valido && !m_pend;
    disp_before = m_disp;
    @(posedge clk);
    if (fb && m_pend) begin
      m_disp = m_buf;
      m_pend = 1'b0;
    end
    if (acc) begin
      m_buf  = dato;
      m_pend = 1'b1;
    end
    ncyc++;
    #1;
    an_exp = ~(4'b0001 << d);
    check("anodos", anodos, an_exp);
    check("segmentos", segs, exp_seg(disp_before, d));
    check("frame", frame, (ncyc % FRAME) == FRAME - 1);
    check("listo", listo, !m_pend);
  endtask

  task automatic steps(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [15:0] v);
    logic a;
    a      = 1'b0;
    valido = 1'b1;
    dato   = v;
    for (int i = 0; i < 64 && !a; i++) step(a);
    check("send_accept", a, 1'b1);
    valido = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    valido = 1'b0;
    #1;
    check("rst_anodos", anodos, 4'b1111);
    check("rst_segs", segs, 7'b1111111);
    check("rst_listo", listo, 1'b1);
    check("rst_frame", frame, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    ncyc   = 0;
    m_pend = 1'b0;
    m_buf  = '0;
    m_disp = '0;
  endtask

  initial begin
    logic a;
    int unsigned d;

    rst    = 1'b1;
    valido = 1'b0;
    dato   = '0;
    ncyc   = 0;
    m_pend = 1'b0;
    m_buf  = '0;
    m_disp = '0;

    tbl[0] = mk(16'h1A8F, 7'b0111000, 7'b0000000, 7'b0001000, 7'b1001111);
    tbl[1] = mk(16'h3C7E, 7'b0110000, 7'b0001111, 7'b0110001, 7'b0000110);
`ifdef LEADING_ZERO_BLANK_EN
    tbl[2] = mk(16'h0050, 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111);
    tbl[3] = mk(16'h0000, 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111);
`else
    tbl[2] = mk(16'h0050, 7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001);
    tbl[3] = mk(16'h0000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
`endif
    tbl[4] = mk(16'h9B26, 7'b0100000, 7'b0010010, 7'b1100000, 7'b0000100);

    // Reset and idle scan: zeros everywhere, frame pulse every 16 cycles.
    apply_reset();
    steps(40);

    // Mid-frame accept, then a second valid while the first is pending.
    while (ncyc % FRAME != 5) step(a);
    send(16'h1A8F);
    valido = 1'b1;
    dato   = 16'h2222;
    step(a);
    check("busy_ignored", a, 1'b0);
    check("listo_busy", listo, 1'b0);
    for (int i = 0; i < 64 && !a; i++) step(a);
    check("retry_accept", a, 1'b1);
    valido = 1'b0;
    steps(40);

    // Table-driven glyph checks across one full frame each.
    for (int t = 0; t < 5; t++) begin
      send(tbl[t].dato);
      steps(40);
      for (int i = 0; i < FRAME; i++) begin
        step(a);
        d = ((ncyc - 1) / PS) % ND;
        check("tbl_seg", segs, tbl[t].exp[d]);
      end
    end

    // Accept coincident with a frame boundary: old value for one more frame.
    while (ncyc % FRAME != FRAME - 1) step(a);
    valido = 1'b1;
    dato   = 16'h3C7E;
    step(a);
    valido = 1'b0;
    check("coinc_accept", a, 1'b1);
    step(a);
    check("coinc_old_d0", segs, 7'b0100000);
    steps(16);
    check("coinc_new_d0", segs, 7'b0110000);
    steps(20);

    // Reset mid-scan with data pending: blanks at once and drops the data.
    send(16'h4444);
    steps(2);
    check("pend_before_rst", listo, 1'b0);
    apply_reset();
    steps(40);

    // Randomized producer traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (!valido && $urandom_range(0, 7) == 0) begin
        valido = 1'b1;
        dato   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      end
      step(a);
      if (a) valido = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
